// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the parametrised tail-light sequencer:
//   - tl_state_e : controller state encoding
//   - sweep()    : lamp mask with the innermost k lamps lit
// ---------------------------------------------------------------------------
package tl_pkg;

    // Widest lamp bank the sweep helper can describe.
    localparam int unsigned TL_MAX_LAMPS = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEFT    = 3'd1,
        RIGHT   = 3'd2,
        HAZ_ON  = 3'd3,
        HAZ_OFF = 3'd4,
        ERR     = 3'd5
    } tl_state_e;

    // Lamps [k-1:0] on, clipped to the bank size; k = 0 gives all off.
    function automatic logic [TL_MAX_LAMPS-1:0] sweep(input int unsigned k,
                                                      input int unsigned lamps);
        logic [TL_MAX_LAMPS-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < TL_MAX_LAMPS; i++) begin
            mask[i] = (i < k) && (i < lamps);
        end
        return mask;
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// ---------------------------------------------------------------------------
// tl_tick_gen
// Free-running divider that produces a one-cycle step strobe every TICK_DIV
// clock cycles. With TICK_DIV = 1 the strobe is permanently high.
// Ports:
//   clka    in  clock, rising edge
//   restart in  synchronous active-high reset, counter back to 0
//   tick    out high while the counter sits at TICK_DIV-1
// ---------------------------------------------------------------------------
module tl_tick_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clka,
    input  logic restart,
    output logic tick
);

    localparam int unsigned     CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at the last value, otherwise increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous restart.
    always_ff @(posedge clka) begin
        if (restart) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/tail_light_seq_param.sv
// ---------------------------------------------------------------------------
// tail_light_seq_param
// Parametrised tail-light controller: sequential turn sweeps, brake overlay,
// hazard flash and a sticky left+right conflict error. All outputs come
// straight from registers that hold the lamp image of the post-edge state.
// Ports:
//   clka    in  clock, rising edge
//   restart in  synchronous active-high reset
//   brake   in  brake pedal
//   left    in  left turn request
//   right   in  right turn request
//   hazard  in  hazard switch (ignored when HAZ_EN = 0)
//   l       out left lamp bank, bit 0 innermost
//   r       out right lamp bank, bit 0 innermost
//   error   out sticky conflict flag, cleared only by restart
// ---------------------------------------------------------------------------
module tail_light_seq_param
    import tl_pkg::*;
#(
    parameter int unsigned LAMPS    = 3,
    parameter int unsigned TICK_DIV = 1,
    parameter bit          HAZ_EN   = 1'b1
) (
    input  logic             clka,
    input  logic             restart,
    input  logic             brake,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    output logic [LAMPS-1:0] l,
    output logic [LAMPS-1:0] r,
    output logic             error
);

    localparam int unsigned       STEP_W   = $clog2(LAMPS + 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(LAMPS);
    localparam logic [LAMPS-1:0]  ALL_ON   = {LAMPS{1'b1}};

    tl_state_e state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [LAMPS-1:0]  l_q, l_d, r_q, r_d;
    logic              error_q, error_d;

    logic                    tick_s;
    logic                    haz_s;
    logic                    conflict_s;
    logic [STEP_W-1:0]       step_inc_s;
    logic [TL_MAX_LAMPS-1:0] sweep_s;
    logic [LAMPS-1:0]        brake_mask_s;

    tl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clka    (clka),
        .restart (restart),
        .tick    (tick_s)
    );

    assign haz_s        = hazard & HAZ_EN;
    // A hazard request legitimately overrides simultaneous turn requests.
    assign conflict_s   = left & right & ~haz_s;
    assign step_inc_s   = (step_q == STEP_MAX) ? '0 : (step_q + STEP_W'(1));
    assign brake_mask_s = brake ? ALL_ON : '0;

    // Next state and step: ERR is absorbing, conflict bypasses the tick.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (state_q == ERR) begin
            state_d = ERR;
        end else if (conflict_s) begin
            state_d = ERR;
        end else if (tick_s) begin
            if (haz_s) begin
                step_d = '0;
                if (state_q == HAZ_ON) begin
                    state_d = HAZ_OFF;
                end else begin
                    state_d = HAZ_ON;
                end
            end else if (left) begin
                state_d = LEFT;
                if (state_q == LEFT) begin
                    step_d = step_inc_s;
                end else begin
                    step_d = STEP_W'(1);
                end
            end else if (right) begin
                state_d = RIGHT;
                if (state_q == RIGHT) begin
                    step_d = step_inc_s;
                end else begin
                    step_d = STEP_W'(1);
                end
            end else begin
                state_d = IDLE;
                step_d  = '0;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Lamp image of the post-edge state, so outputs lag inputs by one edge.
    always_comb begin
        sweep_s = sweep(32'(step_d), LAMPS);
        l_d     = brake_mask_s;
        r_d     = brake_mask_s;
        error_d = 1'b0;
        case (state_d)
            IDLE: begin
                l_d = brake_mask_s;
                r_d = brake_mask_s;
            end
            LEFT: begin
                l_d = sweep_s[LAMPS-1:0];
                r_d = brake_mask_s;
            end
            RIGHT: begin
                l_d = brake_mask_s;
                r_d = sweep_s[LAMPS-1:0];
            end
            HAZ_ON: begin
                l_d = ALL_ON;
                r_d = ALL_ON;
            end
            HAZ_OFF: begin
                l_d = brake_mask_s;
                r_d = brake_mask_s;
            end
            ERR: begin
                // Fail-safe: everything lit.
                l_d     = ALL_ON;
                r_d     = ALL_ON;
                error_d = 1'b1;
            end
            default: begin
                l_d     = ALL_ON;
                r_d     = ALL_ON;
                error_d = 1'b1;
            end
        endcase
    end

    // State, step and output registers with synchronous restart.
    always_ff @(posedge clka) begin
        if (restart) begin
            state_q <= IDLE;
            step_q  <= '0;
            l_q     <= '0;
            r_q     <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            l_q     <= l_d;
            r_q     <= r_d;
            error_q <= error_d;
        end
    end

    assign l     = l_q;
    assign r     = r_q;
    assign error = error_q;

endmodule

// File: tb/tb_tail_light_seq_param.sv
// ---------------------------------------------------------------------------
// tb_tail_light_seq_param
// Three controller instances share one set of driver inputs:
//   A: LAMPS=3 TICK_DIV=1 HAZ_EN=1
//   B: LAMPS=4 TICK_DIV=4 HAZ_EN=1
//   C: LAMPS=3 TICK_DIV=2 HAZ_EN=0
// Each is compared every cycle against a behavioural model that tracks the
// lamp pattern as "mode + lit lamp count + elapsed cycles".
// ---------------------------------------------------------------------------
module tb_tail_light_seq_param;

    logic clka;
    logic restart, brake, left, right, hazard;
    logic [2:0] l_a, r_a, l_c, r_c;
    logic [3:0] l_b, r_b;
    logic       err_a, err_b, err_c;

    int n_tests = 0;
    int n_fail  = 0;

    tail_light_seq_param #(.LAMPS(3), .TICK_DIV(1), .HAZ_EN(1'b1)) dut_a (
        .clka(clka), .restart(restart), .brake(brake), .left(left), .right(right),
        .hazard(hazard), .l(l_a), .r(r_a), .error(err_a));

    tail_light_seq_param #(.LAMPS(4), .TICK_DIV(4), .HAZ_EN(1'b1)) dut_b (
        .clka(clka), .restart(restart), .brake(brake), .left(left), .right(right),
        .hazard(hazard), .l(l_b), .r(r_b), .error(err_b));

    tail_light_seq_param #(.LAMPS(3), .TICK_DIV(2), .HAZ_EN(1'b0)) dut_c (
        .clka(clka), .restart(restart), .brake(brake), .left(left), .right(right),
        .hazard(hazard), .l(l_c), .r(r_c), .error(err_c));

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Configuration of each instance as seen by the model.
    int p_lamps[3] = '{3, 4, 3};
    int p_div[3]   = '{1, 4, 2};
    int p_hazen[3] = '{1, 1, 0};

    // Model state: mode 0=dark/brake only, 1=left sweep, 2=right sweep, 3=flashing.
    int m_elapsed[3];
    int m_mode[3];
    int m_lit[3];
    int m_flash_on[3];
    int m_fault[3];
    int exp_l[3], exp_r[3], exp_e[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Advance one instance's model by one clock edge using the current inputs.
    task automatic model_step(input int k);
        int  all_on, bmask;
        bit  step_now, haz;
        all_on = (1 << p_lamps[k]) - 1;
        bmask  = brake ? all_on : 0;
        if (restart) begin
            m_elapsed[k]  = 0;
            m_mode[k]     = 0;
            m_lit[k]      = 0;
            m_flash_on[k] = 0;
            m_fault[k]    = 0;
            exp_l[k] = 0; exp_r[k] = 0; exp_e[k] = 0;
            return;
        end
        // A step happens on every p_div-th cycle counted from the last restart.
        step_now     = ((m_elapsed[k] % p_div[k]) == p_div[k] - 1);
        m_elapsed[k] = m_elapsed[k] + 1;
        haz          = hazard && (p_hazen[k] != 0);
        if (m_fault[k] == 0) begin
            if (left && right && !haz) begin
                m_fault[k] = 1;
            end else if (step_now) begin
                if (haz) begin
                    m_flash_on[k] = (m_mode[k] == 3) ? !m_flash_on[k] : 1;
                    m_mode[k]     = 3;
                    m_lit[k]      = 0;
                end else if (left || right) begin
                    int want;
                    want = left ? 1 : 2;
                    if (m_mode[k] == want) m_lit[k] = (m_lit[k] + 1) % (p_lamps[k] + 1);
                    else                   m_lit[k] = 1;
                    m_mode[k] = want;
                end else begin
                    m_mode[k] = 0;
                    m_lit[k]  = 0;
                end
            end
        end
        if (m_fault[k] != 0) begin
            exp_l[k] = all_on; exp_r[k] = all_on; exp_e[k] = 1;
        end else begin
            exp_e[k] = 0;
            exp_l[k] = bmask;
            exp_r[k] = bmask;
            if (m_mode[k] == 3 && m_flash_on[k] != 0) begin
                exp_l[k] = all_on; exp_r[k] = all_on;
            end else if (m_mode[k] == 1) begin
                exp_l[k] = (1 << m_lit[k]) - 1;
            end else if (m_mode[k] == 2) begin
                exp_r[k] = (1 << m_lit[k]) - 1;
            end
        end
    endtask

    task automatic check_all();
        chk("A.l", 32'(l_a), exp_l[0]);
        chk("A.r", 32'(r_a), exp_r[0]);
        chk("A.error", 32'(err_a), exp_e[0]);
        chk("B.l", 32'(l_b), exp_l[1]);
        chk("B.r", 32'(r_b), exp_r[1]);
        chk("B.error", 32'(err_b), exp_e[1]);
        chk("C.l", 32'(l_c), exp_l[2]);
        chk("C.r", 32'(r_c), exp_r[2]);
        chk("C.error", 32'(err_c), exp_e[2]);
    endtask

    // Hold one input pattern for n cycles, checking after every edge.
    task automatic drive(input bit rst, input bit brk, input bit lf, input bit rt,
                         input bit hz, input int n);
        for (int i = 0; i < n; i++) begin
            restart = rst; brake = brk; left = lf; right = rt; hazard = hz;
            @(posedge clka);
            for (int k = 0; k < 3; k++) model_step(k);
            @(negedge clka);
            check_all();
        end
    endtask

    initial begin
        restart = 1'b1; brake = 1'b0; left = 1'b0; right = 1'b0; hazard = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_elapsed[k] = 0; m_mode[k] = 0; m_lit[k] = 0; m_flash_on[k] = 0;
            m_fault[k] = 0; exp_l[k] = 0; exp_r[k] = 0; exp_e[k] = 0;
        end
        @(negedge clka);

        // Reset, left sweep, brake overlay, then right sweep.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        // Conflict latches until restart.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        // Hazard alone, with a left+right request, and with brake.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        // Long left sweep for the divided instance, restart mid-sweep.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 22);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12);

        // Randomised segments of held input patterns.
        for (int s = 0; s < 600; s++) begin
            int  pat;
            bit  rst, brk, lf, rt, hz;
            pat = $urandom_range(0, 9);
            rst = ($urandom_range(0, 14) == 0);
            brk = $urandom_range(0, 1);
            hz  = ($urandom_range(0, 5) == 0);
            lf  = (pat <= 3) || (pat == 7);
            rt  = (pat >= 4 && pat <= 6) || (pat == 7);
            drive(rst, brk, lf, rt, hz, rst ? 1 : $urandom_range(1, 10));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
